// File: rtl/bulk_in_packetiser_pkg.sv
// -----------------------------------------------------------------------------
// bulk_in_packetiser_pkg
//   Shared definitions for the bulk IN packetiser.
//   Contents: DATAx PID constants, the packetiser FSM state type and a helper
//   that maps the data-toggle bit onto its PID.
// -----------------------------------------------------------------------------
package bulk_in_packetiser_pkg;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FILL     = 2'd1,
    ST_SEND     = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_t;

  function automatic logic [3:0] pid_for(input logic toggle);
    return toggle ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/bulk_in_packetiser_pkt_buffer_ram.sv
// -----------------------------------------------------------------------------
// bulk_in_packetiser_pkt_buffer_ram
//   Simple dual-port packet retry buffer, one write port and one read port,
//   registered read output (maps onto block RAM).
//   Ports:
//     clock      in   clock for both ports
//     i_wr_en    in   write strobe
//     i_wr_addr  in   write address
//     i_wr_data  in   write data
//     i_rd_en    in   read strobe; o_rd_data holds its value when low
//     i_rd_addr  in   read address
//     o_rd_data  out  data read on the previous enabled cycle
// -----------------------------------------------------------------------------
module bulk_in_packetiser_pkt_buffer_ram #(
  parameter int WIDTH = 8,
  parameter int ABITS = 9
) (
  input  logic             clock,
  input  logic             i_wr_en,
  input  logic [ABITS-1:0] i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [ABITS-1:0] i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [0:(1<<ABITS)-1];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/bulk_in_packetiser.sv
// -----------------------------------------------------------------------------
// bulk_in_packetiser
//   Prefetches up to MAX_PACKET_SIZE bytes from the bulk IN endpoint FIFO into
//   a retry buffer and answers IN tokens with DATA0/DATA1 packets, NAK when no
//   packet is ready, and a trailing zero-length packet when a transfer ends
//   exactly on a packet boundary. Packets are replayed unchanged after a
//   handshake timeout.
//   Ports:
//     clock, reset                    clock and synchronous active-high reset
//     bulk_ep_in_has_data_i           upstream has a packet's worth / tlast
//     bulk_ep_in_xfer_o               high while draining upstream
//     bulk_ep_in_tvalid/tready/tlast/tdata   upstream AXIS byte stream
//     in_token_i, ack_i, timeout_i    protocol events (1-cycle pulses)
//     clear_toggle_i                  force next PID to DATA0
//     nak_o                           1-cycle NAK request
//     tx_tvalid/tready/tlast/tkeep/tdata     TX AXIS byte stream
//     tx_pid_o                        PID of the packet being sent
// -----------------------------------------------------------------------------
module bulk_in_packetiser #(
  parameter int MAX_PACKET_SIZE = 512,
  parameter int BUF_ABITS       = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bulk_ep_in_has_data_i,
  output logic       bulk_ep_in_xfer_o,
  input  logic       bulk_ep_in_tvalid_i,
  output logic       bulk_ep_in_tready_o,
  input  logic       bulk_ep_in_tlast_i,
  input  logic [7:0] bulk_ep_in_tdata_i,
  input  logic       in_token_i,
  input  logic       ack_i,
  input  logic       timeout_i,
  input  logic       clear_toggle_i,
  output logic       nak_o,
  output logic       tx_tvalid_o,
  input  logic       tx_tready_i,
  output logic       tx_tlast_o,
  output logic       tx_tkeep_o,
  output logic [7:0] tx_tdata_o,
  output logic [3:0] tx_pid_o
);

  import bulk_in_packetiser_pkg::*;

  localparam logic [BUF_ABITS:0] C_MAX = (BUF_ABITS+1)'(MAX_PACKET_SIZE);

  state_t             r_state;
  state_t             w_state_next;
  logic [BUF_ABITS:0] r_count;
  logic [BUF_ABITS:0] r_len;
  logic [BUF_ABITS:0] r_rd_addr;
  logic [BUF_ABITS:0] w_count_inc;
  logic               r_pending;
  logic               r_zlp_pending;
  logic               r_toggle;
  logic               r_zlp_mode;
  logic               r_tx_valid;
  logic               r_tx_last;
  logic               r_nak;
  logic [3:0]         r_pid;
  logic               w_fill_beat;
  logic               w_fill_end;
  logic               w_send_start;
  logic               w_more;
  logic               w_advance;
  logic               w_issue;
  logic               w_nak_next;
  logic [7:0]         w_rd_data;

  assign w_count_inc = r_count + 1'b1;
  assign w_fill_beat = (r_state == ST_FILL) && bulk_ep_in_tvalid_i && bulk_ep_in_tready_o;
  // The TX output register can take a new beat when empty or being drained.
  assign w_advance   = !r_tx_valid || tx_tready_i;
  // A ZLP is a single synthetic beat; otherwise read until len bytes issued.
  assign w_more      = r_zlp_mode ? (r_rd_addr == '0) : (r_rd_addr < r_len);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_send_start = 1'b0;
    w_nak_next   = 1'b0;
    w_fill_end   = 1'b0;
    w_issue      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_token_i) begin
          if (r_pending || r_zlp_pending) begin
            w_state_next = ST_SEND;
            w_send_start = 1'b1;
          end else begin
            w_nak_next = 1'b1;
          end
        end else if (bulk_ep_in_has_data_i && !r_pending && !r_zlp_pending) begin
          w_state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        w_nak_next = in_token_i;
        if (w_fill_beat && (bulk_ep_in_tlast_i || (w_count_inc == C_MAX))) begin
          w_fill_end   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_SEND: begin
        w_issue = w_advance && w_more;
        if (r_tx_valid && tx_tready_i && r_tx_last) begin
          w_state_next = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_i || timeout_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count       <= '0;
      r_len         <= '0;
      r_rd_addr     <= '0;
      r_pending     <= 1'b0;
      r_zlp_pending <= 1'b0;
      r_toggle      <= 1'b0;
      r_zlp_mode    <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_tx_last     <= 1'b0;
      r_nak         <= 1'b0;
      r_pid         <= 4'h0;
    end else begin
      r_nak <= w_nak_next;

      if (r_state == ST_IDLE) begin
        r_count <= '0;
      end else if (w_fill_beat) begin
        r_count <= w_count_inc;
      end

      if (w_fill_end) begin
        r_pending     <= 1'b1;
        r_len         <= w_count_inc;
        // A transfer ending exactly on a full packet owes the host a ZLP.
        r_zlp_pending <= bulk_ep_in_tlast_i && (w_count_inc == C_MAX);
      end

      if (w_send_start) begin
        r_zlp_mode <= !r_pending;
        r_pid      <= pid_for(r_toggle);
        r_rd_addr  <= '0;
        r_tx_valid <= 1'b0;
        r_tx_last  <= 1'b0;
      end else if ((r_state == ST_SEND) && w_advance) begin
        r_tx_valid <= w_issue;
        if (w_issue) begin
          r_rd_addr <= r_rd_addr + 1'b1;
          r_tx_last <= r_zlp_mode || (r_rd_addr == (r_len - 1'b1));
        end
      end

      if ((r_state == ST_WAIT_ACK) && ack_i) begin
        if (r_zlp_mode) begin
          r_zlp_pending <= 1'b0;
        end else begin
          r_pending <= 1'b0;
        end
        r_toggle <= !r_toggle;
      end

      // Placed last so it overrides an ack flip in the same cycle.
      if (clear_toggle_i) begin
        r_toggle <= 1'b0;
      end
    end
  end

  bulk_in_packetiser_pkt_buffer_ram #(
    .WIDTH (8),
    .ABITS (BUF_ABITS)
  ) u_pkt_buffer_ram (
    .clock     (clock),
    .i_wr_en   (w_fill_beat),
    .i_wr_addr (r_count[BUF_ABITS-1:0]),
    .i_wr_data (bulk_ep_in_tdata_i),
    .i_rd_en   (w_issue && !r_zlp_mode),
    .i_rd_addr (r_rd_addr[BUF_ABITS-1:0]),
    .o_rd_data (w_rd_data)
  );

  assign bulk_ep_in_xfer_o   = (r_state == ST_FILL);
  assign bulk_ep_in_tready_o = (r_state == ST_FILL) && (r_count < C_MAX);
  assign nak_o               = r_nak;
  assign tx_tvalid_o         = r_tx_valid;
  assign tx_tlast_o          = r_tx_valid && r_tx_last;
  assign tx_tkeep_o          = r_tx_valid && !r_zlp_mode;
  assign tx_tdata_o          = tx_tkeep_o ? w_rd_data : 8'h00;
  assign tx_pid_o            = r_pid;

endmodule
